// File: rtl/bluster_pkg.sv
// rtl/bluster_pkg.sv - shared state encoding and limits for the Zorro bus master
package bluster_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_REQ       = 3'd1,
    S_WAIT_FREE = 3'd2,
    S_OWN       = 3'd3,
    S_RELEASE   = 3'd4
  } state_e;

  localparam logic [7:0] TENURE_MAX = 8'd255;

  // BRn is held low only while we are asking for, or waiting to use, the bus.
  function automatic logic is_req_phase(input state_e s);
    return (s == S_REQ) || (s == S_WAIT_FREE);
  endfunction

endpackage

// File: rtl/bus_sync.sv
// rtl/bus_sync.sv - two-flop synchronizer for asynchronous bus inputs, resets to 1
module bus_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  // Two-stage capture; resets to the negated (high) level of active-low strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
    end
  end

  assign o_sync = r_sync;

endmodule

// File: rtl/zorro_bus_master.sv
// rtl/zorro_bus_master.sv - Zorro II DMA bus master arbitration; optional macro TENURE_LIMIT_EN
module zorro_bus_master
  import bluster_pkg::*;
(
  input  logic C7M,
  input  logic RESETn,
  output logic BRn,
  input  logic BGn,
  inout  wire  BGACKn,
  input  logic ASn,
  input  logic DTACKn,
  output logic OWNn,
  input  logic dma_req,
  input  logic dma_done,
  output logic dma_gnt,
  output logic dma_abort
);

  state_e     r_state;
  state_e     w_next;
  logic       r_brn;
  logic       r_ownn;
  logic       r_gnt;
  logic       r_bgack_drv;
  logic       r_abort;
  logic       w_abort_next;
  logic       w_brn_next;
  logic       w_tenure_hit;
  logic [3:0] w_sync;
  logic       w_bg_s;
  logic       w_as_s;
  logic       w_dtack_s;
  logic       w_bgack_s;
  logic       w_bus_free;

  bus_sync #(.WIDTH(4)) u_sync (
    .clk     (C7M),
    .rst_n   (RESETn),
    .i_async ({BGn, ASn, DTACKn, BGACKn}),
    .o_sync  (w_sync)
  );

  assign {w_bg_s, w_as_s, w_dtack_s, w_bgack_s} = w_sync;

  // The previous master has fully let go only when no strobe and no acknowledge remain.
  assign w_bus_free = w_as_s & w_dtack_s & w_bgack_s;

`ifdef TENURE_LIMIT_EN
  logic [7:0] r_tenure;

  // Counts OWN cycles; sits at zero outside OWN so every tenure starts fresh.
  always_ff @(posedge C7M or negedge RESETn) begin
    if (!RESETn) begin
      r_tenure <= '0;
    end else if (r_state != S_OWN) begin
      r_tenure <= '0;
    end else begin
      r_tenure <= r_tenure + 8'd1;
    end
  end

  assign w_tenure_hit = (r_state == S_OWN) && (r_tenure == TENURE_MAX);
`else
  assign w_tenure_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge C7M or negedge RESETn) begin
    if (!RESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state decode; a normal end of tenure beats the tenure limit.
  always_comb begin
    w_next       = r_state;
    w_abort_next = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (dma_req) w_next = S_REQ;
      end
      S_REQ: begin
        if (!dma_req)     w_next = S_IDLE;
        else if (!w_bg_s) w_next = S_WAIT_FREE;
      end
      S_WAIT_FREE: begin
        if (!dma_req)                  w_next = S_IDLE;
        else if (!w_bg_s && w_bus_free) w_next = S_OWN;
      end
      S_OWN: begin
        if (dma_done || !dma_req) begin
          w_next = S_RELEASE;
        end else if (w_tenure_hit) begin
          w_next       = S_RELEASE;
          w_abort_next = 1'b1;
        end
      end
      S_RELEASE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
    w_brn_next = !(is_req_phase(r_state) && is_req_phase(w_next));
  end

  // Bus-facing outputs are registered from the next state so they switch with it.
  always_ff @(posedge C7M or negedge RESETn) begin
    if (!RESETn) begin
      r_brn       <= 1'b1;
      r_ownn      <= 1'b1;
      r_gnt       <= 1'b0;
      r_bgack_drv <= 1'b0;
      r_abort     <= 1'b0;
    end else begin
      r_brn       <= w_brn_next;
      r_ownn      <= (w_next != S_OWN);
      r_gnt       <= (w_next == S_OWN);
      r_bgack_drv <= (w_next == S_OWN);
      r_abort     <= w_abort_next;
    end
  end

  assign BRn       = r_brn;
  assign OWNn      = r_ownn;
  assign dma_gnt   = r_gnt;
  assign dma_abort = r_abort;
  assign BGACKn    = r_bgack_drv ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_zorro_bus_master.sv
// tb/tb_zorro_bus_master.sv - self-checking bench for zorro_bus_master
module tb_zorro_bus_master;
  import bluster_pkg::*;

  logic C7M      = 1'b0;
  logic RESETn   = 1'b0;
  logic BGn      = 1'b1;
  logic ASn      = 1'b1;
  logic DTACKn   = 1'b1;
  logic dma_req  = 1'b0;
  logic dma_done = 1'b0;
  logic BRn;
  logic OWNn;
  logic dma_gnt;
  logic dma_abort;
  wire  BGACKn;

  pullup (BGACKn);

  int total = 0;
  int bad   = 0;

  zorro_bus_master dut (
    .C7M       (C7M),
    .RESETn    (RESETn),
    .BRn       (BRn),
    .BGn       (BGn),
    .BGACKn    (BGACKn),
    .ASn       (ASn),
    .DTACKn    (DTACKn),
    .OWNn      (OWNn),
    .dma_req   (dma_req),
    .dma_done  (dma_done),
    .dma_gnt   (dma_gnt),
    .dma_abort (dma_abort)
  );

  always #5 C7M = ~C7M;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge C7M);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkn(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Requests the bus, grants it, optionally keeps the bus busy, and reports
  // how many edges after the grant the card took ownership.
  task automatic acquire(input int busy, input bit use_dtack, output int lat, output bit brn_held);
    dma_req = 1'b1;
    tick();
    check1("brn_high_on_req_entry", BRn, 1'b1);
    tick();
    check1("brn_low_after_req_entry", BRn, 1'b0);
    BGn = 1'b0;
    if (busy > 0) begin
      if (use_dtack) DTACKn = 1'b0;
      else           ASn    = 1'b0;
    end
    brn_held = 1'b1;
    lat      = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (i == busy) begin
        ASn    = 1'b1;
        DTACKn = 1'b1;
      end
      if (BGACKn === 1'b0) begin
        lat = i;
        break;
      end
      if (BRn !== 1'b0) brn_held = 1'b0;
    end
    BGn = 1'b1;
  endtask

  task automatic check_owned(input string tag);
    check1({tag, "_brn"},  BRn,     1'b1);
    check1({tag, "_ownn"}, OWNn,    1'b0);
    check1({tag, "_gnt"},  dma_gnt, 1'b1);
  endtask

  task automatic check_released(input string tag);
    check1({tag, "_ownn"},   OWNn,      1'b1);
    check1({tag, "_gnt"},    dma_gnt,   1'b0);
    check1({tag, "_bgackn"}, BGACKn,    1'b1);
    check1({tag, "_abort"},  dma_abort, 1'b0);
  endtask

  initial begin
    int  lat;
    bit  held;
    int  busy;
    bit  use_dtack;
    int  hold;
    int  own_cnt;
    int  exp_lat;
    bit  stayed;

    // Reset values.
    #12;
    check1("rst_brn",    BRn,       1'b1);
    check1("rst_ownn",   OWNn,      1'b1);
    check1("rst_bgackn", BGACKn,    1'b1);
    check1("rst_gnt",    dma_gnt,   1'b0);
    check1("rst_abort",  dma_abort, 1'b0);
    #5 RESETn = 1'b1;
    repeat (3) tick();

    // Request withdrawn before any grant.
    dma_req = 1'b1;
    tick();
    tick();
    check1("withdraw_brn_low", BRn, 1'b0);
    dma_req = 1'b0;
    tick();
    check1("withdraw_brn_high", BRn, 1'b1);
    check1("withdraw_no_bgack", BGACKn, 1'b1);
    repeat (3) tick();

    // dma_done outside OWN changes nothing.
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check1("done_idle_brn", BRn, 1'b1);
    check1("done_idle_ownn", OWNn, 1'b1);
    dma_req = 1'b1;
    tick();
    tick();
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check1("done_req_brn", BRn, 1'b0);
    dma_req = 1'b0;
    tick();
    check1("done_req_exit", BRn, 1'b1);
    repeat (3) tick();

    // Randomized tenures: grant latency follows the synchronizer delay plus the
    // two state steps, or the bus-busy time plus sync and one step, whichever is later.
    for (int n = 0; n < 8; n++) begin
      busy      = $urandom_range(0, 8);
      use_dtack = 1'($urandom_range(0, 1));
      hold      = $urandom_range(1, 12);
      exp_lat   = (busy + 3 > 4) ? busy + 3 : 4;
      acquire(busy, use_dtack, lat, held);
      checkn("rand_grant_latency", lat, exp_lat);
      check1("rand_brn_held", held, 1'b1);
      check_owned("rand_own");
      own_cnt = 0;
      for (int k = 0; k < hold; k++) begin
        tick();
        if (OWNn === 1'b0 && BGACKn === 1'b0) own_cnt++;
      end
      checkn("rand_own_hold", own_cnt, hold);
      if (n[0]) begin
        dma_done = 1'b1;
        tick();
        dma_done = 1'b0;
        dma_req  = 1'b0;
      end else begin
        dma_req = 1'b0;
        tick();
      end
      check_released("rand_release");
      tick();
      check1("rand_idle_brn", BRn, 1'b1);
      check1("rand_idle_bgackn", BGACKn, 1'b1);
      check1("rand_idle_ownn", OWNn, 1'b1);
      repeat (4) tick();
    end

    // Grant withdrawn while waiting for a busy bus, then returned.
    dma_req = 1'b1;
    tick();
    tick();
    BGn = 1'b0;
    ASn = 1'b0;
    repeat (5) tick();
    BGn = 1'b1;
    repeat (2) tick();
    ASn = 1'b1;
    repeat (4) tick();
    check1("regrant_wait_bgackn", BGACKn, 1'b1);
    check1("regrant_wait_brn", BRn, 1'b0);
    BGn = 1'b0;
    lat = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (BGACKn === 1'b0) begin
        lat = i;
        break;
      end
    end
    BGn = 1'b1;
    checkn("regrant_latency", lat, 3);
    check_owned("regrant_own");

    // dma_done with dma_req still high: one idle cycle before the next REQ.
    dma_done = 1'b1;
    tick();
    dma_done = 1'b0;
    check_released("b2b_release");
    tick();
    check1("b2b_idle_bgackn", BGACKn, 1'b1);
    check1("b2b_idle_brn", BRn, 1'b1);
    tick();
    check1("b2b_req_entry_brn", BRn, 1'b1);
    tick();
    check1("b2b_req_brn", BRn, 1'b0);
    dma_req = 1'b0;
    tick();
    check1("b2b_drop_brn", BRn, 1'b1);
    check1("b2b_drop_bgackn", BGACKn, 1'b1);
    repeat (4) tick();

`ifdef TENURE_LIMIT_EN
    // Held request: tenure is cut after TENURE_MAX+1 OWN cycles with one abort pulse.
    acquire(0, 1'b0, lat, held);
    checkn("tenure_grant_latency", lat, 4);
    own_cnt = 1;
    stayed  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (OWNn === 1'b1) begin
        stayed = 1'b1;
        break;
      end
      own_cnt++;
    end
    check1("tenure_released", stayed, 1'b1);
    checkn("tenure_own_cycles", own_cnt, int'(TENURE_MAX) + 1);
    check1("tenure_abort_pulse", dma_abort, 1'b1);
    check1("tenure_release_bgackn", BGACKn, 1'b1);
    tick();
    check1("tenure_abort_one_cycle", dma_abort, 1'b0);
    dma_req = 1'b0;
    repeat (4) tick();
`else
    // Held request: tenure is unlimited and no abort appears.
    acquire(0, 1'b0, lat, held);
    checkn("unlimited_grant_latency", lat, 4);
    own_cnt = 0;
    stayed  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (OWNn !== 1'b0 || dma_abort !== 1'b0) stayed = 1'b0;
      own_cnt++;
    end
    check1("unlimited_kept_bus", stayed, 1'b1);
    checkn("unlimited_cycles", own_cnt, 300);
    dma_req = 1'b0;
    tick();
    check_released("unlimited_release");
    repeat (4) tick();
`endif

    // Reset in the middle of a tenure releases the bus without a clock edge.
    acquire(2, 1'b1, lat, held);
    checkn("rstown_grant_latency", lat, 5);
    tick();
    #2;
    RESETn = 1'b0;
    #1;
    check1("rstown_bgackn", BGACKn,    1'b1);
    check1("rstown_ownn",   OWNn,      1'b1);
    check1("rstown_brn",    BRn,       1'b1);
    check1("rstown_gnt",    dma_gnt,   1'b0);
    check1("rstown_abort",  dma_abort, 1'b0);
    dma_req = 1'b0;
    #13;
    RESETn = 1'b1;
    repeat (3) tick();
    check1("rstown_after_ownn", OWNn, 1'b1);
    check1("rstown_after_abort", dma_abort, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
